// File: rtl/ste_shift_ctrl_if.sv
// Handshake/control bundle between the frame source, ste_shift_ctrl and the downstream shift register.
// master = word source / observer, slave = ste_shift_ctrl.
`timescale 1ns/1ps
interface ste_shift_ctrl_if #(
    parameter int SHIFT_W = 16,
    parameter int DIV_W   = 8
);
    localparam int CNT_W = $clog2(SHIFT_W + 1);

    logic [SHIFT_W-1:0] tx_data_i;
    logic               tx_valid_i;
    logic               tx_ready_o;
    logic [DIV_W-1:0]   div_i;
    logic               abort_i;
    logic [SHIFT_W-1:0] din_parallel_o;
    logic               shift_ld_o;
    logic               shift_en_o;
    logic               shift_clr_o;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   bit_cnt_o;

    modport master (
        output tx_data_i, tx_valid_i, div_i, abort_i,
        input  tx_ready_o, din_parallel_o, shift_ld_o, shift_en_o,
               shift_clr_o, busy_o, done_o, bit_cnt_o
    );

    modport slave (
        input  tx_data_i, tx_valid_i, div_i, abort_i,
        output tx_ready_o, din_parallel_o, shift_ld_o, shift_en_o,
               shift_clr_o, busy_o, done_o, bit_cnt_o
    );
endinterface

// File: rtl/ste_shift_ctrl.sv
// Frame sequencer driving load/shift/clear strobes of ste_shift_reg: one load, then SHIFT_W shift pulses.
// Optional STE_SHIFT_CTRL_BACK2BACK_EN: accept the next word while in DONE.
`timescale 1ns/1ps
module ste_shift_ctrl #(
    parameter int SHIFT_W = 16,
    parameter int DIV_W   = 8
) (
    input logic           clk,
    input logic           reset_i,
    ste_shift_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(SHIFT_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SHIFT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] din_q, din_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic tx_ready;
    logic accept;
    logic tick;

    always_comb begin
        tx_ready = (state_q == S_IDLE);
`ifdef STE_SHIFT_CTRL_BACK2BACK_EN
        // Abort in DONE wins over a new handshake.
        if (state_q == S_DONE && !bus.abort_i) begin
            tx_ready = 1'b1;
        end
`endif
    end

    assign accept = bus.tx_valid_i && tx_ready;
    assign tick   = (div_cnt_q == div_q);

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    din_d   = bus.tx_data_i;
                    div_d   = bus.div_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = bus.abort_i ? S_CLEAR : S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.abort_i) begin
                    state_d = S_CLEAR;
                end else if (tick) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                if (bus.abort_i) begin
                    state_d = S_CLEAR;
                end else if (accept) begin
                    din_d   = bus.tx_data_i;
                    div_d   = bus.div_i;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            din_q     <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Strobes decode from registered state; abort only masks shift/done in its own cycle.
    assign bus.tx_ready_o     = tx_ready;
    assign bus.din_parallel_o = din_q;
    assign bus.shift_ld_o     = (state_q == S_LOAD);
    assign bus.shift_en_o     = (state_q == S_SHIFT) && tick && !bus.abort_i;
    assign bus.shift_clr_o    = (state_q == S_CLEAR);
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.done_o         = (state_q == S_DONE) && !bus.abort_i;
    assign bus.bit_cnt_o      = bit_cnt_q;
endmodule

// File: tb/tb_ste_shift_ctrl.sv
// Scoreboard bench for ste_shift_ctrl: frame-level model predicts strobe events, negedge monitor checks them.
`timescale 1ns/1ps
module tb_ste_shift_ctrl;
    localparam int W  = 16;
    localparam int DW = 8;
    localparam int EV_LD = 0, EV_EN = 1, EV_DONE = 2, EV_CLR = 3, EV_RDY = 4;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   free_cyc = 0;
    bit   mon_en = 1'b0;
    logic prev_rdy = 1'b1;
    logic [W-1:0] sr;
    ev_t  sb[$];
    string nm[5] = '{"ld", "en", "done", "clr", "rdy"};

    ste_shift_ctrl_if #(.SHIFT_W(W), .DIV_W(DW)) bus ();

    ste_shift_ctrl #(.SHIFT_W(W), .DIV_W(DW)) dut (
        .clk    (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream shift register stand-in, driven by the DUT strobes.
    always @(posedge clk or posedge reset_i) begin
        if (reset_i) sr <= '0;
        else if (bus.shift_ld_o) sr <= bus.din_parallel_o;
        else if (bus.shift_en_o) sr <= sr << 1;
        else if (bus.shift_clr_o) sr <= '0;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic mon_event(input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got event at cycle %0d expected none", nm[kind], cyc);
        end else begin
            e = sb.pop_front();
            chk({"kind_", nm[kind]}, kind, e.kind);
            chk({"cycle_", nm[kind]}, cyc, e.cyc);
            chk({"value_", nm[kind]}, val, e.val);
        end
    endtask

    always @(negedge clk) begin
        int ns;
        if (mon_en) begin
            ns = int'(bus.shift_ld_o) + int'(bus.shift_en_o) + int'(bus.shift_clr_o);
            if (ns > 0) chk("strobe_exclusive", ns, 1);
            if (bus.shift_ld_o)  mon_event(EV_LD, int'(bus.din_parallel_o));
            if (bus.shift_en_o)  mon_event(EV_EN, int'(bus.bit_cnt_o) * 2 + int'(sr[W-1]));
            if (bus.done_o)      mon_event(EV_DONE, int'(bus.bit_cnt_o));
            if (bus.shift_clr_o) mon_event(EV_CLR, int'(bus.din_parallel_o));
            if (bus.tx_ready_o && !prev_rdy) mon_event(EV_RDY, int'(sr));
        end
        prev_rdy = bus.tx_ready_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.tx_data_i = W'($urandom);
        bus.div_i     = DW'($urandom);
    endtask

    // Offer one word; the model predicts the accept cycle from when the block becomes free.
    task automatic send(input logic [W-1:0] data, input int d, input int ab_off,
                        input int idle, output int acc);
        int a, n, dn, c;
        repeat (idle) step();
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = data;
        bus.div_i      = DW'(d);
        a  = (cyc > free_cyc) ? cyc : free_cyc;
        n  = (ab_off >= 0) ? a + ab_off : -1;
        dn = a + 2 + W * (d + 1);
        acc = a;
        push(EV_LD, a + 1, int'(data));
        for (int k = 1; k <= W; k++) begin
            c = a + 1 + k * (d + 1);
            if (n >= 0 && c >= n) break;
            push(EV_EN, c, (k - 1) * 2 + int'(data[W-k]));
        end
        if (n < 0) begin
            push(EV_DONE, dn, W);
`ifdef STE_SHIFT_CTRL_BACK2BACK_EN
            push(EV_RDY, dn, 0);
            free_cyc = dn;
`else
            push(EV_RDY, dn + 1, 0);
            free_cyc = dn + 1;
`endif
        end else begin
            push(EV_CLR, n + 1, int'(data));
            push(EV_RDY, n + 2, 0);
            free_cyc = n + 2;
        end
        while (cyc < a) step();
        step();
        bus.tx_valid_i = 1'b0;
        scramble();
        if (n >= 0) begin
            while (cyc < n) begin
                step();
                scramble();
            end
            bus.abort_i = 1'b1;
            step();
            bus.abort_i = 1'b0;
        end
    endtask

    initial begin
        int acc, d, ab;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = '0;
        bus.div_i      = '0;
        bus.abort_i    = 1'b0;
        repeat (3) step();
        chk("rst_ready", int'(bus.tx_ready_o), 1);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_strobes", int'({bus.shift_ld_o, bus.shift_en_o, bus.shift_clr_o}), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_din", int'(bus.din_parallel_o), 0);
        chk("rst_bitcnt", int'(bus.bit_cnt_o), 0);
        reset_i  = 1'b0;
        free_cyc = cyc;
        mon_en   = 1'b1;

        send(16'hA5C3, 0, -1, 0, acc);
        send(16'h0001, 3, -1, 3, acc);
        send(16'hBEEF, 1, 8, 2, acc);
        send(16'h1234, 0, -1, 4, acc);
        send(16'hFFFF, 0, -1, 0, acc);
        send(16'h8001, 2, 1, 1, acc);
        send(16'h7E7E, 2, 7, 0, acc);
        send(16'hC3A5, 1, 2 + W * 2, 0, acc);
        send(16'h5555, 255, -1, 1, acc);
        for (int i = 0; i < 20; i++) begin
            d  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + W * (d + 1)) : -1;
            send(W'($urandom), d, ab, $urandom_range(0, 4), acc);
        end

        // Reset in the middle of a frame.
        send(16'hC0DE, 0, -1, 0, acc);
        while (cyc < acc + 7) step();
        mon_en = 1'b0;
        sb.delete();
        reset_i = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy_o), 0);
        chk("midrst_en", int'(bus.shift_en_o), 0);
        chk("midrst_bitcnt", int'(bus.bit_cnt_o), 0);
        chk("midrst_ready", int'(bus.tx_ready_o), 1);
        step();
        step();
        reset_i  = 1'b0;
        free_cyc = cyc;
        mon_en   = 1'b1;
        send(16'h0F0F, 2, -1, 0, acc);

        while (cyc < free_cyc + 3) step();
        chk("scoreboard_empty", sb.size(), 0);
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            $display("FAIL missing_%s: got nothing expected event at cycle %0d", nm[e.kind], e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
